// File: rtl/bus_timer_array.sv
// rtl/bus_timer_array.sv - multi-channel bus-mapped interval timer
//
// Purpose: NUM_CH independent 8-bit down-counters. All channels share one
// free-running prescaler. Each channel has a one-shot or periodic mode, an
// interrupt enable and a sticky pending bit, all mapped onto the 8-bit bus.
//
// Ports:
//   CLK                  system clock
//   RESET                synchronous, active-high reset
//   BUS_DATA             shared data bus; driven only for this block's reads
//   BUS_ADDR             bus address
//   BUS_WE               bus write enable
//   BUS_INTERRUPT_RAISE  registered timer interrupt request
//   BUS_INTERRUPT_ACK    one-cycle acknowledge from the processor
module bus_timer_array #(
  parameter int unsigned NUM_CH    = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned PRESCALE  = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PW         = $clog2(PRESCALE);
  localparam logic [7:0]  STATUS_OFF = 8'(2 * NUM_CH);
  // The window is padded to an even length. Its top address is reserved:
  // reads return 0 and writes are ignored.
  localparam logic [7:0]  LAST_OFF   = 8'(2 * NUM_CH + 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        period_q [NUM_CH];
  logic [7:0]        period_d [NUM_CH];
  logic [7:0]        count_q  [NUM_CH];
  logic [7:0]        count_d  [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
  logic [NUM_CH-1:0] event_v;
  logic              raise_q, raise_d;
  logic              rd_en_q, rd_en_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic [7:0] offset;
  logic       in_win, wr, rd, tick;

  assign offset  = BUS_ADDR - BASE_ADDR;
  assign in_win  = (BUS_ADDR >= BASE_ADDR) && (offset <= LAST_OFF);
  assign wr      = in_win && BUS_WE;
  assign rd      = in_win && !BUS_WE;
  assign tick    = (presc_q == PW'(PRESCALE - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Channel state. A register write to a channel takes priority over a
  // coincident tick: the counter reloads and that tick is lost for the
  // channel. Because of this, a write that clears EN also suppresses a
  // coincident event.
  always_comb begin
    pend_d  = pend_q;
    event_v = '0;
    if (BUS_INTERRUPT_ACK) begin
      pend_d = '0;
    end
    if (wr && (offset == STATUS_OFF)) begin
      pend_d = pend_d & ~BUS_DATA[NUM_CH-1:0];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      en_d[i]     = en_q[i];
      per_d[i]    = per_q[i];
      ie_d[i]     = ie_q[i];
      if (wr && (offset == 8'(2 * i))) begin
        period_d[i] = BUS_DATA;
        count_d[i]  = BUS_DATA;
      end else if (wr && (offset == 8'(2 * i + 1))) begin
        en_d[i]    = BUS_DATA[0];
        per_d[i]   = BUS_DATA[1];
        ie_d[i]    = BUS_DATA[2];
        count_d[i] = period_q[i];
      end else if (tick && en_q[i]) begin
        if (count_q[i] != 8'd0) begin
          count_d[i] = count_q[i] - 8'd1;
        end else begin
          event_v[i] = 1'b1;
          if (per_q[i]) begin
            count_d[i] = period_q[i];
          end else begin
            en_d[i] = 1'b0;
          end
        end
      end
    end
    // New events are applied after the clears, so an event that coincides
    // with an ACK or a STATUS clear leaves its pending bit set.
    pend_d = pend_d | event_v;
  end

  // Read data is captured from the state at the address cycle.
  always_comb begin
    rd_data_d = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (offset == 8'(2 * i)) begin
        rd_data_d = period_q[i];
      end
      if (offset == 8'(2 * i + 1)) begin
        rd_data_d = {pend_q[i], 4'b0000, ie_q[i], per_q[i], en_q[i]};
      end
    end
    if (offset == STATUS_OFF) begin
      rd_data_d = 8'(pend_q);
    end
    if (!rd) begin
      rd_data_d = 8'h00;
    end
  end

  assign rd_en_d = rd;
  assign raise_d = |(pend_q & ie_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q   <= '0;
      en_q      <= '0;
      per_q     <= '0;
      ie_q      <= '0;
      pend_q    <= '0;
      raise_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= 8'h00;
        count_q[i]  <= 8'h00;
      end
    end else begin
      presc_q   <= presc_d;
      en_q      <= en_d;
      per_q     <= per_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      raise_q   <= raise_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
